// File: rtl/pw_trigger_sequencer.sv
// pw_trigger_sequencer
//
// Single-shot pulse-train generator. A rising edge on I_arm latches the
// delay/width/gap/count settings and arms the sequencer. The next match
// pulse then starts a delay, followed by a train of pulses on O_trigger.
// Dropping I_arm at any point after arming aborts the train silently.
//
// Ports
//   trigger_clk      sole clock, rising edge
//   reset_i          synchronous, active-high reset
//   I_arm            arm level (already synchronous to trigger_clk)
//   I_match_trigger  single-cycle match pulse
//   I_delay          cycles from match to first pulse
//   I_width          pulse high time (0 behaves as 1)
//   I_gap            low time between pulses (0 behaves as 1)
//   I_count          pulses per sequence (0 behaves as 1)
//   O_trigger        registered trigger output
//   O_armed          high while armed and waiting for a match
//   O_busy           high during delay / pulse / gap
//   O_done           one-cycle pulse when a train completes normally
module pw_trigger_sequencer #(
  parameter int pDELAY_WIDTH = 20,
  parameter int pPULSE_WIDTH = 17,
  parameter int pCOUNT_WIDTH = 8
) (
  input  logic                    trigger_clk,
  input  logic                    reset_i,
  input  logic                    I_arm,
  input  logic                    I_match_trigger,
  input  logic [pDELAY_WIDTH-1:0] I_delay,
  input  logic [pPULSE_WIDTH-1:0] I_width,
  input  logic [pPULSE_WIDTH-1:0] I_gap,
  input  logic [pCOUNT_WIDTH-1:0] I_count,
  output logic                    O_trigger,
  output logic                    O_armed,
  output logic                    O_busy,
  output logic                    O_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_PULSE,
    S_GAP
  } state_t;

  state_t state_q, state_d;

  logic arm_prev_q, arm_prev_d;
  logic arm_seen_low_q, arm_seen_low_d;

  logic [pDELAY_WIDTH-1:0] delay_q, delay_d;
  logic [pPULSE_WIDTH-1:0] width_q, width_d;
  logic [pPULSE_WIDTH-1:0] gap_q, gap_d;
  logic [pCOUNT_WIDTH-1:0] count_q, count_d;

  logic [pDELAY_WIDTH-1:0] dly_cnt_q, dly_cnt_d;
  logic [pPULSE_WIDTH-1:0] pw_cnt_q, pw_cnt_d;
  logic [pCOUNT_WIDTH-1:0] pulses_left_q, pulses_left_d;

  logic trigger_q, trigger_d;
  logic armed_q, armed_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic arm_rise;

  // Cycles-minus-one for a width/gap setting, with 0 treated as 1.
  function automatic logic [pPULSE_WIDTH-1:0] len_m1(input logic [pPULSE_WIDTH-1:0] v);
    return (v == '0) ? '0 : v - pPULSE_WIDTH'(1);
  endfunction

  // Pulse count with 0 treated as 1.
  function automatic logic [pCOUNT_WIDTH-1:0] count_norm(input logic [pCOUNT_WIDTH-1:0] v);
    return (v == '0) ? pCOUNT_WIDTH'(1) : v;
  endfunction

  // A level that was already high when reset released must not arm: the
  // edge detector is only trusted once I_arm has been seen low.
  assign arm_rise = I_arm & ~arm_prev_q & arm_seen_low_q;

  always_comb begin
    state_d        = state_q;
    arm_prev_d     = I_arm;
    arm_seen_low_d = arm_seen_low_q | ~I_arm;
    delay_d        = delay_q;
    width_d        = width_q;
    gap_d          = gap_q;
    count_d        = count_q;
    dly_cnt_d      = dly_cnt_q;
    pw_cnt_d       = pw_cnt_q;
    pulses_left_d  = pulses_left_q;
    done_d         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (arm_rise) begin
          state_d = S_ARMED;
          delay_d = I_delay;
          width_d = I_width;
          gap_d   = I_gap;
          count_d = I_count;
        end
      end

      S_ARMED: begin
        if (!I_arm) begin
          state_d = S_IDLE;
        end else if (I_match_trigger) begin
          pulses_left_d = count_norm(count_q);
          // Zero delay skips DELAY so the pulse starts on the cycle after match.
          if (delay_q == '0) begin
            state_d  = S_PULSE;
            pw_cnt_d = len_m1(width_q);
          end else begin
            state_d   = S_DELAY;
            dly_cnt_d = delay_q - pDELAY_WIDTH'(1);
          end
        end
      end

      S_DELAY: begin
        if (!I_arm) begin
          state_d = S_IDLE;
        end else if (dly_cnt_q == '0) begin
          state_d  = S_PULSE;
          pw_cnt_d = len_m1(width_q);
        end else begin
          dly_cnt_d = dly_cnt_q - pDELAY_WIDTH'(1);
        end
      end

      S_PULSE: begin
        if (!I_arm) begin
          state_d = S_IDLE;
        end else if (pw_cnt_q == '0) begin
          if (pulses_left_q == pCOUNT_WIDTH'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d       = S_GAP;
            pw_cnt_d      = len_m1(gap_q);
            pulses_left_d = pulses_left_q - pCOUNT_WIDTH'(1);
          end
        end else begin
          pw_cnt_d = pw_cnt_q - pPULSE_WIDTH'(1);
        end
      end

      S_GAP: begin
        if (!I_arm) begin
          state_d = S_IDLE;
        end else if (pw_cnt_q == '0) begin
          state_d  = S_PULSE;
          pw_cnt_d = len_m1(width_q);
        end else begin
          pw_cnt_d = pw_cnt_q - pPULSE_WIDTH'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    trigger_d = (state_d == S_PULSE);
    armed_d   = (state_d == S_ARMED);
    busy_d    = (state_d == S_DELAY) || (state_d == S_PULSE) || (state_d == S_GAP);
  end

  always_ff @(posedge trigger_clk) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      arm_prev_q     <= 1'b0;
      arm_seen_low_q <= 1'b0;
      delay_q        <= '0;
      width_q        <= '0;
      gap_q          <= '0;
      count_q        <= '0;
      dly_cnt_q      <= '0;
      pw_cnt_q       <= '0;
      pulses_left_q  <= '0;
      trigger_q      <= 1'b0;
      armed_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      arm_prev_q     <= arm_prev_d;
      arm_seen_low_q <= arm_seen_low_d;
      delay_q        <= delay_d;
      width_q        <= width_d;
      gap_q          <= gap_d;
      count_q        <= count_d;
      dly_cnt_q      <= dly_cnt_d;
      pw_cnt_q       <= pw_cnt_d;
      pulses_left_q  <= pulses_left_d;
      trigger_q      <= trigger_d;
      armed_q        <= armed_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign O_trigger = trigger_q;
  assign O_armed   = armed_q;
  assign O_busy    = busy_q;
  assign O_done    = done_q;

endmodule
